pipeif_fetch: RTL
=================

Name: pipeif_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It feeds the decode stage with dpc4/inst and consumes that stage's pcsource, bpc, jpc, da (jr target) and wpcir.
It owns the PC and presents the fetch address to a variable-latency instruction memory (ready handshake). It implements MIPS single-delay-slot semantics. A redirect decided while the delay slot is still outstanding is held in a pending-redirect register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, bubble instruction inserted into IF/ID when fetch is not complete (sll r0,r0,0).

Ports:
clock  input  1  rising-edge clock.
resetn  input  1  asynchronous active-low reset.
pcsource  input  2  next-PC select from decode: 00 = pc+4, 01 = bpc, 10 = da (jr), 11 = jpc.
bpc  input  32  branch target from decode.
jpc  input  32  jump target from decode.
da  input  32  forwarded rs value from decode (jr target).
wpcir  input  1  1 = pipeline may advance; 0 = load-use stall, hold PC and IF/ID.
imem_rdata  input  32  instruction word at imem_addr; valid when imem_ready=1.
imem_ready  input  1  imem_rdata valid this cycle.
imem_addr  output  32  current PC (combinational from pc register).
imem_req  output  1  fetch request; 0 during reset, 1 otherwise.
pc  output  32  current PC register.
dpc4  output  32  IF/ID register: PC+4 of the instruction in decode.
inst  output  32  IF/ID register: instruction in decode.
redirect_pend  output  1  pending-redirect register valid (debug/verification visibility).

Behaviour:
- Reset (resetn=0, async): pc=RESET_PC, dpc4=0, inst=NOP_INST, redirect_pend=0, pend_target=0, imem_req=0. First request is on the first clock after deassertion.
- Definitions: pc4 = pc + 32'd4 (mod 2^32, wrap allowed). redir = wpcir & (pcsource != 00). tgt = bpc / da / jpc per pcsource. adv = wpcir & imem_ready.
- Stall (wpcir=0): pc, dpc4, inst, redirect_pend and pend_target all hold. imem_ready is ignored. The memory re-presents the same address next cycle. pcsource is ignored during stall because its operands may be unresolved.
- Fetch complete (adv=1):
  - dpc4 <= pc4, inst <= imem_rdata.
  - Next pc, by priority:
    1. redir: pc <= tgt. The word just fetched is the delay slot.
    2. redirect_pend: pc <= pend_target, then clear redirect_pend.
    3. Otherwise: pc <= pc4.
- Fetch incomplete (wpcir=1, imem_ready=0):
  - dpc4 <= pc4, inst <= NOP_INST (bubble).
  - pc holds.
  - If redir: pend_target <= tgt, redirect_pend <= 1. The delay slot is not yet fetched; the redirect is applied when it completes.
- Invariant: redir and redirect_pend are never both 1. While redirect_pend=1 the decode stage holds only bubbles or the delay slot, and neither produces pcsource != 00. The bench asserts this invariant.
- Latency:
  - Instruction fetched at cycle n (adv) is in decode (inst) from cycle n+1.
  - Redirect at cycle n with adv=1: the target address is presented at cycle n+1.
- A bubble in decode decodes as sll r0 and produces pcsource=00, so no spurious redirect.
- Reset asserted mid-pending discards pend_target. The PC restarts at RESET_PC regardless of outstanding memory response.
- Target alignment is not checked. Low two bits of da propagate unchanged.

Test Plan:
1. Reset, imem_ready=1, wpcir=1, pcsource=00 -> imem_addr 0,4,8,C on consecutive cycles; inst follows one cycle later; dpc4 = addr+4.
2. At pc=0x10, hold wpcir=0 for 2 cycles -> pc stays 0x10, inst/dpc4 frozen; on release, fetch resumes at 0x10 with no instruction lost or duplicated.
3. beq in decode at pc_id=0x20, pcsource=01, bpc=0x100, imem_ready=1 -> delay slot 0x24 enters IF/ID; next imem_addr=0x100.
4. Same beq with imem_ready=0 for 3 cycles -> redirect_pend=1, inst=NOP_INST each cycle, pc=0x24. When ready rises, 0x24 enters IF/ID, pc=0x100, redirect_pend clears.
5. jr with da=0x0000_0400 (pcsource=10) and j with jpc=0x0040_0000 (pcsource=11) -> after the delay slot, pc=0x400 and pc=0x0040_0000 respectively.
6. Reset pulsed while redirect_pend=1 -> immediately pc=RESET_PC, inst=NOP_INST, redirect_pend=0; next fetch from RESET_PC, pending target never used.

Source files
------------

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage and IF/ID pipeline register with MIPS single-delay-slot redirect
// handling over a variable-latency instruction memory.
module pipeif_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] da,
    input  logic        wpcir,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        redirect_pend
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic [31:0] inst_q, inst_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic [31:0] pc4;
    logic [31:0] tgt;
    logic        redir;
    logic        adv;

    always_comb begin
        pc4   = pc_q + 32'd4;
        redir = wpcir & (pcsource != 2'b00);
        adv   = wpcir & imem_ready;
        case (pcsource)
            2'b01:   tgt = bpc;
            2'b10:   tgt = da;
            2'b11:   tgt = jpc;
            default: tgt = pc4;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        dpc4_d        = dpc4_q;
        inst_d        = inst_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;

        if (adv) begin
            dpc4_d = pc4;
            inst_d = imem_rdata;
            // A fresh redirect makes the word just fetched its delay slot; otherwise a
            // pending redirect fires now that its delay slot has arrived.
            if (redir) begin
                pc_d = tgt;
            end else if (pend_q) begin
                pc_d   = pend_target_q;
                pend_d = 1'b0;
            end else begin
                pc_d = pc4;
            end
        end else if (wpcir) begin
            dpc4_d = pc4;
            inst_d = NOP_INST;
            if (redir) begin
                pend_target_d = tgt;
                pend_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_q          <= RESET_PC;
            dpc4_q        <= 32'h0000_0000;
            inst_q        <= NOP_INST;
            pend_q        <= 1'b0;
            pend_target_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            dpc4_q        <= dpc4_d;
            inst_q        <= inst_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign imem_addr     = pc_q;
    assign imem_req      = resetn;
    assign pc            = pc_q;
    assign dpc4          = dpc4_q;
    assign inst          = inst_q;
    assign redirect_pend = pend_q;

endmodule
